// File: rtl/chip8_ram_arbiter.sv
// chip8_ram_arbiter
//   Shares the single-port CHIP-8 RAM (ram2) between the ROM loader, the CPU
//   and the display fetch unit. The loader owns the RAM during BOOT. After it
//   signals done, the CPU and the display share the RAM round-robin. In RUN
//   the loader only gets the leftover cycles.
//
//   Ports
//     CLOCK_50, reset_n               clock, async active-low reset
//     ld_*  (req/we/addr/wdata/done)  loader port; ld_gnt accepts the access
//     cpu_* (req/we/addr/wdata)       CPU port; cpu_gnt accepts the access
//     vid_* (req/addr)                display fetch port (read-only); vid_gnt
//     rdata, *_rvalid                 shared read data and per-port valid
//     cpu_run                         high once boot has finished
//     ram_address/ram_data/ram_wren   to ram2; ram_q comes back from ram2
module chip8_ram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              ld_rvalid,
    output logic              cpu_rvalid,
    output logic              vid_rvalid,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {BOOT, RUN} state_t;

    // Read tags carried down the latency pipe; TAG_NONE marks an empty slot.
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_LD   = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;
    localparam logic [1:0] TAG_VID  = 2'd3;

    localparam logic RR_CPU = 1'b0;
    localparam logic RR_VID = 1'b1;

    state_t state_q, state_d;
    logic   rr_ptr_q;   // port granted last among CPU/display

    logic              any_gnt;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [1:0]        gnt_tag;
    logic [1:0]        tag_in;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [READ_LATENCY-1:0][1:0] vld_pipe;
    logic [1:0]        tag_out;

    // ---------------- FSM ----------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state_q <= BOOT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && ld_done) state_d = RUN;
    end

    assign cpu_run = (state_q == RUN);

    // ---------------- arbitration ----------------
    // Grants are forced low while reset is asserted so nothing reaches the
    // RAM before the FSM is in a known state.
    always_comb begin
        ld_gnt  = 1'b0;
        cpu_gnt = 1'b0;
        vid_gnt = 1'b0;
        if (reset_n) begin
            if (state_q == BOOT) begin
                ld_gnt = ld_req;
            end else if (cpu_req && vid_req) begin
                if (rr_ptr_q == RR_CPU) vid_gnt = 1'b1;
                else                    cpu_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (vid_req) begin
                vid_gnt = 1'b1;
            end else begin
                ld_gnt = ld_req;
            end
        end
    end

    always_comb begin
        any_gnt  = 1'b1;
        gnt_we   = 1'b0;
        gnt_addr = addr_q;
        gnt_data = data_q;
        gnt_tag  = TAG_NONE;
        if (ld_gnt) begin
            gnt_we = ld_we;   gnt_addr = ld_addr;  gnt_data = ld_wdata;  gnt_tag = TAG_LD;
        end else if (cpu_gnt) begin
            gnt_we = cpu_we;  gnt_addr = cpu_addr; gnt_data = cpu_wdata; gnt_tag = TAG_CPU;
        end else if (vid_gnt) begin
            gnt_addr = vid_addr; gnt_tag = TAG_VID;
        end else begin
            any_gnt = 1'b0;
        end
    end

    // Without a grant the bus keeps its last address/data; only wren drops.
    assign ram_address = gnt_addr;
    assign ram_data    = gnt_data;
    assign ram_wren    = any_gnt & gnt_we;
    assign tag_in      = (any_gnt && !gnt_we) ? gnt_tag : TAG_NONE;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= RR_CPU;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            if (cpu_gnt)      rr_ptr_q <= RR_CPU;
            else if (vid_gnt) rr_ptr_q <= RR_VID;
            if (any_gnt) begin
                addr_q <= gnt_addr;
                data_q <= gnt_data;
            end
        end
    end

    // ---------------- read return ----------------
    // One slot per cycle of RAM latency; the tag leaving the last slot lines
    // up with ram_q for that read, so ordering follows grant order.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign tag_out    = vld_pipe[READ_LATENCY-1];
    assign ld_rvalid  = (tag_out == TAG_LD);
    assign cpu_rvalid = (tag_out == TAG_CPU);
    assign vid_rvalid = (tag_out == TAG_VID);
    assign rdata      = ram_q;

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
module tb_chip8_ram_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        ld_req, ld_we, ld_done, ld_gnt;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        cpu_req, cpu_we, cpu_gnt;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        vid_req, vid_gnt;
    logic [11:0] vid_addr;
    logic [7:0]  rdata;
    logic        ld_rvalid, cpu_rvalid, vid_rvalid, cpu_run;
    logic [11:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [7:0]  ram_q;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    chip8_ram_arbiter #(.ADDR_W(12), .DATA_W(8), .READ_LATENCY(1)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_gnt(ld_gnt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .rdata(rdata), .ld_rvalid(ld_rvalid), .cpu_rvalid(cpu_rvalid), .vid_rvalid(vid_rvalid),
        .cpu_run(cpu_run),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // ram2 model: registered address, write-then-read returns new data
    logic [7:0]  mem [4096];
    logic [11:0] q_addr;
    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        q_addr <= ram_address;
    end
    assign ram_q = mem[q_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld_req, ld_we;
        logic [11:0] ld_addr;
        logic [7:0]  ld_wdata;
        logic        ld_done;
        logic        cpu_req, cpu_we;
        logic [11:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic        vid_req;
        logic [11:0] vid_addr;
        logic [2:0]  gnt;   // {ld, cpu, vid}
        logic [2:0]  rv;    // {ld, cpu, vid}
        logic        run;
        logic        wren;
        logic [7:0]  rd;
    } vec_t;

    localparam int NV = 20;
    vec_t v [NV];

    initial begin
        // boot: loader writes 0x200..0x203 while the CPU knocks in vain
        v[0]  = '{1'b1,1'b1,12'h200,8'h12,1'b0, 1'b1,1'b0,12'h201,8'h00, 1'b0,12'h000, 3'b100,3'b000,1'b0,1'b1,8'h00};
        v[1]  = '{1'b1,1'b1,12'h201,8'h34,1'b0, 1'b1,1'b0,12'h201,8'h00, 1'b0,12'h000, 3'b100,3'b000,1'b0,1'b1,8'h00};
        v[2]  = '{1'b1,1'b1,12'h202,8'h56,1'b0, 1'b1,1'b0,12'h201,8'h00, 1'b0,12'h000, 3'b100,3'b000,1'b0,1'b1,8'h00};
        v[3]  = '{1'b1,1'b1,12'h203,8'h78,1'b0, 1'b1,1'b0,12'h201,8'h00, 1'b0,12'h000, 3'b100,3'b000,1'b0,1'b1,8'h00};
        // loader read with ld_done in the same cycle; its rvalid lands in RUN
        v[4]  = '{1'b1,1'b0,12'h200,8'h00,1'b1, 1'b1,1'b0,12'h201,8'h00, 1'b0,12'h000, 3'b100,3'b000,1'b0,1'b0,8'h00};
        v[5]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h201,8'h00, 1'b0,12'h000, 3'b010,3'b100,1'b1,1'b0,8'h12};
        v[6]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b1,12'h202, 3'b001,3'b010,1'b1,1'b0,8'h34};
        // CPU and display both requesting: display went last, so C,V,C,V,C,V
        v[7]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h203,8'h00, 1'b1,12'h200, 3'b010,3'b001,1'b1,1'b0,8'h56};
        v[8]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h203,8'h00, 1'b1,12'h200, 3'b001,3'b010,1'b1,1'b0,8'h78};
        v[9]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h203,8'h00, 1'b1,12'h200, 3'b010,3'b001,1'b1,1'b0,8'h12};
        v[10] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h203,8'h00, 1'b1,12'h200, 3'b001,3'b010,1'b1,1'b0,8'h78};
        v[11] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h203,8'h00, 1'b1,12'h200, 3'b010,3'b001,1'b1,1'b0,8'h12};
        v[12] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h203,8'h00, 1'b1,12'h200, 3'b001,3'b010,1'b1,1'b0,8'h78};
        // CPU write 0x300 then read it back, then display reads it
        v[13] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b1,12'h300,8'hAB, 1'b0,12'h000, 3'b010,3'b001,1'b1,1'b1,8'h12};
        v[14] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h300,8'h00, 1'b0,12'h000, 3'b010,3'b000,1'b1,1'b0,8'h00};
        v[15] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b1,12'h300, 3'b001,3'b010,1'b1,1'b0,8'hAB};
        // loader in RUN waits for the CPU, then gets the cycle it drops
        v[16] = '{1'b1,1'b1,12'h400,8'h55,1'b0, 1'b1,1'b0,12'h201,8'h00, 1'b0,12'h000, 3'b010,3'b001,1'b1,1'b0,8'hAB};
        v[17] = '{1'b1,1'b1,12'h400,8'h55,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b0,12'h000, 3'b100,3'b010,1'b1,1'b1,8'h34};
        v[18] = '{1'b1,1'b0,12'h400,8'h00,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b0,12'h000, 3'b100,3'b000,1'b1,1'b0,8'h00};
        v[19] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b0,12'h000, 3'b000,3'b100,1'b1,1'b0,8'h55};

        // reset state, with requests present
        reset_n = 1'b0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h010; ld_wdata = 8'h99; ld_done = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
        vid_req = 1'b1; vid_addr = 12'h000;
        #5;
        chk("reset_gnt", {ld_gnt, cpu_gnt, vid_gnt}, 3'b000);
        chk("reset_rvalid", {ld_rvalid, cpu_rvalid, vid_rvalid}, 3'b000);
        chk("reset_run", cpu_run, 1'b0);
        chk("reset_wren", ram_wren, 1'b0);
        ld_req = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge CLOCK_50);
            ld_req = v[i].ld_req;   ld_we = v[i].ld_we;   ld_addr = v[i].ld_addr;
            ld_wdata = v[i].ld_wdata; ld_done = v[i].ld_done;
            cpu_req = v[i].cpu_req; cpu_we = v[i].cpu_we; cpu_addr = v[i].cpu_addr;
            cpu_wdata = v[i].cpu_wdata;
            vid_req = v[i].vid_req; vid_addr = v[i].vid_addr;
            #1;
            chk($sformatf("v%0d_gnt", i), {ld_gnt, cpu_gnt, vid_gnt}, v[i].gnt);
            chk($sformatf("v%0d_rvalid", i), {ld_rvalid, cpu_rvalid, vid_rvalid}, v[i].rv);
            chk($sformatf("v%0d_run", i), cpu_run, v[i].run);
            chk($sformatf("v%0d_wren", i), ram_wren, v[i].wren);
            if (v[i].rv != 3'b000) chk($sformatf("v%0d_rdata", i), rdata, v[i].rd);
        end

        // reset while a CPU read is outstanding
        @(negedge CLOCK_50);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h201;
        #1 chk("rst_mid_gnt", cpu_gnt, 1'b1);
        @(posedge CLOCK_50);
        #1 reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rst_mid_rvalid", cpu_rvalid, 1'b0);
        chk("rst_mid_run", cpu_run, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLOCK_50);
            chk("rst_hold_rvalid", {ld_rvalid, cpu_rvalid, vid_rvalid}, 3'b000);
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        cpu_req = 1'b1;
        #1 chk("post_rst_cpu_gnt", cpu_gnt, 1'b0);
        @(negedge CLOCK_50);
        chk("post_rst_rvalid", cpu_rvalid, 1'b0);
        chk("post_rst_run", cpu_run, 1'b0);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'h300;
        #1 chk("post_rst_ld_gnt", {ld_gnt, cpu_gnt, vid_gnt}, 3'b100);
        @(negedge CLOCK_50);
        ld_req = 1'b0; cpu_req = 1'b0;
        #1;
        chk("post_rst_ld_rvalid", ld_rvalid, 1'b1);
        chk("post_rst_ld_rdata", rdata, 8'hAB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
